// File: rtl/mdio_slave_if.sv
// Clause-22 MDIO management slave.
// MDC and MDIO are oversampled in the clk domain. Each MDC rising edge advances
// the frame decoder by one bit. Decoded frames become single-cycle register read
// and write strobes. The pad output enable and data are registered.
module mdio_slave_if #(
    parameter logic [4:0] PHY_ADDR    = 5'h01,
    parameter int         PRE_LEN     = 32,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_o,
    output logic        mdio_oen,
    output logic [4:0]  reg_addr,
    output logic        reg_wr,
    output logic [15:0] reg_wdata,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    output logic        busy
);

    localparam int            PW      = $clog2(PRE_LEN + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRE_LEN);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ST2,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA_RD,
        S_DATA_WR,
        S_SKIP
    } state_t;

    // synchronisers and edge history
    logic [SYNC_STAGES-1:0] r_mdc_sync;
    logic [SYNC_STAGES-1:0] r_mdio_sync;
    logic                   r_mdc_prev;

    // frame decoder state
    state_t                 r_state;
    logic [PW-1:0]          r_pre_cnt;
    logic [4:0]             r_bit_cnt;
    logic [15:0]            r_shift;
    logic                   r_is_read;
    logic                   r_match;

    // registered outputs
    logic                   r_mdio_o;
    logic                   r_mdio_oen;
    logic [4:0]             r_reg_addr;
    logic                   r_reg_wr;
    logic [15:0]            r_reg_wdata;
    logic                   r_reg_rd;
    logic                   r_busy;

    // next-state values
    state_t                 w_state_nxt;
    logic [PW-1:0]          w_pre_nxt;
    logic [4:0]             w_bit_cnt_nxt;
    logic [15:0]            w_shift_nxt;
    logic                   w_is_read_nxt;
    logic                   w_match_nxt;
    logic                   w_o_nxt;
    logic                   w_oen_nxt;
    logic [4:0]             w_addr_nxt;
    logic                   w_wr_nxt;
    logic [15:0]            w_wdata_nxt;
    logic                   w_rd_nxt;
    logic                   w_busy_nxt;

    logic                   w_rise;
    logic                   w_bit;
    logic [4:0]             w_field;
    logic [15:0]            w_wshift;
    logic [1:0]             w_op;

    // Idle levels are 1 for both lines, so resetting the chains to 1 avoids a
    // spurious rise event when reset is released while MDC is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdc_sync  <= '1;
            r_mdio_sync <= '1;
            r_mdc_prev  <= 1'b1;
        end else begin
            r_mdc_sync  <= {r_mdc_sync[SYNC_STAGES-2:0], mdc};
            r_mdio_sync <= {r_mdio_sync[SYNC_STAGES-2:0], mdio_in};
            r_mdc_prev  <= r_mdc_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise   = r_mdc_sync[SYNC_STAGES-1] & ~r_mdc_prev;
    assign w_bit    = r_mdio_sync[SYNC_STAGES-1];
    assign w_field  = {r_shift[3:0], w_bit};
    assign w_wshift = {r_shift[14:0], w_bit};
    assign w_op     = {r_shift[0], w_bit};

    // Next-state and output decode, evaluated only on an MDC rise
    always_comb begin
        w_state_nxt   = r_state;
        w_pre_nxt     = r_pre_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_is_read_nxt = r_is_read;
        w_match_nxt   = r_match;
        w_o_nxt       = r_mdio_o;
        w_oen_nxt     = r_mdio_oen;
        w_addr_nxt    = r_reg_addr;
        w_wr_nxt      = 1'b0;
        w_wdata_nxt   = r_reg_wdata;
        w_rd_nxt      = 1'b0;
        w_busy_nxt    = r_busy;

        if (w_rise) begin
            case (r_state)
                S_IDLE: begin
                    if (w_bit) begin
                        if (r_pre_cnt < PRE_MAX) begin
                            w_pre_nxt = r_pre_cnt + 1'b1;
                        end
                    end else if (r_pre_cnt >= PRE_MAX) begin
                        w_state_nxt = S_ST2;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_pre_nxt = '0;
                    end
                end
                S_ST2: begin
                    if (w_bit) begin
                        w_state_nxt = S_OP;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_OP: begin
                    w_shift_nxt = w_wshift;
                    if (r_bit_cnt == 5'd1) begin
                        if (w_op == 2'b10) begin
                            w_is_read_nxt = 1'b1;
                            w_state_nxt   = S_PHYAD;
                        end else if (w_op == 2'b01) begin
                            w_is_read_nxt = 1'b0;
                            w_state_nxt   = S_PHYAD;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                S_PHYAD: begin
                    w_shift_nxt = w_wshift;
                    if (r_bit_cnt == 5'd4) begin
                        w_match_nxt = (w_field == PHY_ADDR);
                        w_state_nxt = S_REGAD;
                    end
                end
                S_REGAD: begin
                    w_shift_nxt = w_wshift;
                    if (r_bit_cnt == 5'd4) begin
                        if (!r_match) begin
                            w_state_nxt = S_SKIP;
                        end else begin
                            w_addr_nxt  = w_field;
                            w_rd_nxt    = r_is_read;
                            w_state_nxt = S_TA;
                        end
                    end
                end
                S_TA: begin
                    if (r_is_read) begin
                        // TA bit1 turns the pad around and drives the TA zero;
                        // the following rise presents the data MSB.
                        if (r_bit_cnt == 5'd1) begin
                            w_shift_nxt = reg_rdata;
                            w_o_nxt     = 1'b0;
                            w_oen_nxt   = 1'b0;
                        end else if (r_bit_cnt == 5'd2) begin
                            w_o_nxt     = r_shift[15];
                            w_shift_nxt = {r_shift[14:0], 1'b0};
                            w_state_nxt = S_DATA_RD;
                        end
                    end else if (r_bit_cnt == 5'd1) begin
                        w_state_nxt = S_DATA_WR;
                    end
                end
                S_DATA_RD: begin
                    if (r_bit_cnt == 5'd15) begin
                        w_o_nxt     = 1'b1;
                        w_oen_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_o_nxt     = r_shift[15];
                        w_shift_nxt = {r_shift[14:0], 1'b0};
                    end
                end
                S_DATA_WR: begin
                    w_shift_nxt = w_wshift;
                    if (r_bit_cnt == 5'd15) begin
                        w_wdata_nxt = w_wshift;
                        w_wr_nxt    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_SKIP: begin
                    // TA plus 16 data bits of a frame addressed elsewhere
                    if (r_bit_cnt == 5'd17) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase

            // Every return to IDLE demands a fresh preamble and ends the frame.
            if ((w_state_nxt == S_IDLE) && (r_state != S_IDLE)) begin
                w_pre_nxt  = '0;
                w_busy_nxt = 1'b0;
            end

            if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
                w_bit_cnt_nxt = '0;
            end else begin
                w_bit_cnt_nxt = r_bit_cnt + 5'd1;
            end
        end
    end

    // Frame decoder state register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pre_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_is_read   <= 1'b0;
            r_match     <= 1'b0;
            r_mdio_o    <= 1'b1;
            r_mdio_oen  <= 1'b1;
            r_reg_addr  <= '0;
            r_reg_wr    <= 1'b0;
            r_reg_wdata <= '0;
            r_reg_rd    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pre_cnt   <= w_pre_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_is_read   <= w_is_read_nxt;
            r_match     <= w_match_nxt;
            r_mdio_o    <= w_o_nxt;
            r_mdio_oen  <= w_oen_nxt;
            r_reg_addr  <= w_addr_nxt;
            r_reg_wr    <= w_wr_nxt;
            r_reg_wdata <= w_wdata_nxt;
            r_reg_rd    <= w_rd_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign mdio_o    = r_mdio_o;
    assign mdio_oen  = r_mdio_oen;
    assign reg_addr  = r_reg_addr;
    assign reg_wr    = r_reg_wr;
    assign reg_wdata = r_reg_wdata;
    assign reg_rd    = r_reg_rd;
    assign busy      = r_busy;

endmodule
